prio_encoder_pipe: RTL and testbench

- Parametrised, registered N-to-log2(N) priority encoder with a valid/ready handshake on both sides.
- Two selectable arbitration modes: fixed priority, where the highest index wins, and round-robin, where the search starts from a rotating pointer.
- Also reports zero-input and multiple-hot conditions.
- Sits between request sources (interrupt lines, channel requests) and a downstream consumer that needs one encoded index per transaction.

---
 rtl/prio_enc_pkg.sv | 8 +
 rtl/prio_enc_core.sv | 58 +++++
 rtl/prio_encoder_pipe.sv | 96 +++++++++
 tb/tb_prio_encoder_pipe.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared constants for the pipelined priority encoder.
package prio_enc_pkg;

  // Arbitration modes selected by the MODE parameter of prio_encoder_pipe.
  localparam int MODE_FIXED = 0;  // highest set index wins
  localparam int MODE_RR    = 1;  // first set bit at or after the rotating pointer wins

endpackage

// File: rtl/prio_enc_core.sv
// Combinational priority search over an N-bit request vector.
// Fixed mode returns the highest set index. Round-robin mode scans {req, req}
// from base upward and folds the hit position back into 0..N-1.
// any/multi report one-or-more and two-or-more set bits respectively.
module prio_enc_core
  import prio_enc_pkg::*;
#(
  parameter  int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         multi
);

  logic [2*N-1:0] dbl;
  logic           found;
  int             scan_pos;

  assign dbl = {req, req};

  // Population flags plus the mode-dependent winner search.
  always_comb begin
    idx      = '0;
    any      = 1'b0;
    multi    = 1'b0;
    found    = 1'b0;
    scan_pos = 0;
    for (int k = 0; k < N; k++) begin
      if (req[k]) begin
        multi = multi | any;
        any   = 1'b1;
      end
    end
    if (mode) begin
      // Window base..base+N-1 of the doubled vector covers every bit once,
      // in rotated order, so the first hit is the round-robin winner.
      for (int k = 0; k < N; k++) begin
        scan_pos = int'(base) + k;
        if (!found && dbl[scan_pos]) begin
          found = 1'b1;
          idx   = (scan_pos >= N) ? W'(scan_pos - N) : W'(scan_pos);
        end
      end
    end else begin
      // Ascending scan; the last set bit seen is the highest index.
      for (int k = 0; k < N; k++) begin
        if (req[k]) begin
          idx = W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/prio_encoder_pipe.sv
// Registered N-to-log2(N) priority encoder with valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; a producer keeps valid (and its data) until it transfers, and ready may
// depend combinationally on the downstream ready (req_ready = !out_valid || out_ready),
// which gives a single-entry stage that sustains one result per cycle.
module prio_encoder_pipe
  import prio_enc_pkg::*;
#(
  parameter  int N    = 16,
  parameter  int MODE = MODE_FIXED,
  localparam int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         req_valid,
  output logic         req_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_v,
  output logic         out_multi
);

  if (N < 2) begin : g_bad_n
    $error("prio_encoder_pipe: N must be at least 2");
  end

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic         v_q, v_d;
  logic         multi_q, multi_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic [W-1:0] core_idx;
  logic         core_any;
  logic         core_multi;

  prio_enc_core #(.N(N)) u_core (
    .req   (req),
    .base  (ptr_q),
    .mode  (MODE == MODE_RR),
    .idx   (core_idx),
    .any   (core_any),
    .multi (core_multi)
  );

  assign req_ready = !valid_q || out_ready;
  assign accept    = req_valid && req_ready;

  // Next-state for the result register and the round-robin pointer.
  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    v_d     = v_q;
    multi_d = multi_q;
    ptr_d   = ptr_q;
    if (accept) begin
      valid_d = 1'b1;
      idx_d   = core_idx;
      v_d     = core_any;
      multi_d = core_multi;
      // An empty request leaves the pointer where it was; wrap is explicit so a
      // non-power-of-two N never lets the pointer reach N.
      if (MODE == MODE_RR && core_any) begin
        ptr_d = (core_idx == W'(N - 1)) ? '0 : core_idx + 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Result and pointer registers; reset drops any pending result at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      v_q     <= 1'b0;
      multi_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      v_q     <= v_d;
      multi_q <= multi_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_v     = v_q;
  assign out_multi = multi_q;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Bench for prio_encoder_pipe: three instances (N=16 fixed, N=16 round-robin,
// N=10 round-robin) sharing clock and reset, each driven on its own.
module tb_prio_encoder_pipe;

  logic clk;
  logic rst_n;

  logic [15:0] a_req;
  logic        a_rv, a_rr, a_ov, a_ordy, a_v, a_multi;
  logic [3:0]  a_idx;

  logic [15:0] b_req;
  logic        b_rv, b_rr, b_ov, b_ordy, b_v, b_multi;
  logic [3:0]  b_idx;

  logic [9:0]  c_req;
  logic        c_rv, c_rr, c_ov, c_ordy, c_v, c_multi;
  logic [3:0]  c_idx;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] req;
    logic [3:0]  idx;
    logic        v;
    logic        multi;
  } vec_t;

  vec_t tbl[$];

  prio_encoder_pipe #(.N(16), .MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(a_req), .req_valid(a_rv), .req_ready(a_rr),
    .out_valid(a_ov), .out_ready(a_ordy), .out_idx(a_idx), .out_v(a_v), .out_multi(a_multi)
  );

  prio_encoder_pipe #(.N(16), .MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .req_valid(b_rv), .req_ready(b_rr),
    .out_valid(b_ov), .out_ready(b_ordy), .out_idx(b_idx), .out_v(b_v), .out_multi(b_multi)
  );

  prio_encoder_pipe #(.N(10), .MODE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(c_req), .req_valid(c_rv), .req_ready(c_rr),
    .out_valid(c_ov), .out_ready(c_ordy), .out_idx(c_idx), .out_v(c_v), .out_multi(c_multi)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard-style check of instance A's output fields.
  task automatic chk_a(input string name, input logic [3:0] idx, input logic v, input logic multi);
    chk({name, ".valid"}, 32'(a_ov), 32'd1);
    chk({name, ".idx"}, 32'(a_idx), 32'(idx));
    chk({name, ".v"}, 32'(a_v), 32'(v));
    chk({name, ".multi"}, 32'(a_multi), 32'(multi));
  endtask

  initial begin
    logic [3:0] exp_b_idx[4];
    logic [3:0] exp_b_ptr[4];
    logic [3:0] exp_c_idx[3];
    logic [3:0] exp_c_ptr[3];

    checks   = 0;
    failures = 0;
    a_req = '0; a_rv = 0; a_ordy = 1;
    b_req = '0; b_rv = 0; b_ordy = 1;
    c_req = '0; c_rv = 0; c_ordy = 1;

    // Reset sequence.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_a_valid", 32'(a_ov), 0);
    chk("rst_a_idx", 32'(a_idx), 0);
    chk("rst_a_v", 32'(a_v), 0);
    chk("rst_a_multi", 32'(a_multi), 0);
    chk("rst_a_ready", 32'(a_rr), 1);
    chk("rst_b_valid", 32'(b_ov), 0);
    chk("rst_b_ptr", 32'(dut_b.ptr_q), 0);
    chk("rst_c_valid", 32'(c_ov), 0);
    chk("rst_c_ptr", 32'(dut_c.ptr_q), 0);

    // Fixed-priority vectors, streamed back to back with out_ready=1.
    for (int i = 15; i >= 0; i--) tbl.push_back('{16'(1) << i, 4'(i), 1'b1, 1'b0});
    tbl.push_back('{16'h8421, 4'd15, 1'b1, 1'b1});
    tbl.push_back('{16'h0000, 4'd0,  1'b0, 1'b0});
    tbl.push_back('{16'hFFFF, 4'd15, 1'b1, 1'b1});
    tbl.push_back('{16'h0300, 4'd9,  1'b1, 1'b1});
    tbl.push_back('{16'h0001, 4'd0,  1'b1, 1'b0});
    tbl.push_back('{16'h0006, 4'd2,  1'b1, 1'b1});

    @(negedge clk);
    a_rv = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      a_req = tbl[i].req;
      chk($sformatf("fix%0d_ready", i), 32'(a_rr), 1);
      step();
      chk_a($sformatf("fix%0d", i), tbl[i].idx, tbl[i].v, tbl[i].multi);
    end
    chk("fix_ptr_stays0", 32'(dut_a.ptr_q), 0);

    // Backpressure on A: first result idx 4, then stall for 3 cycles.
    a_req = 16'h0010;
    step();
    chk_a("bp_first", 4'd4, 1'b1, 1'b0);
    a_ordy = 1'b0;
    a_req  = 16'h8000;
    #1;
    chk("bp_ready_low", 32'(a_rr), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a($sformatf("bp_hold%0d", i), 4'd4, 1'b1, 1'b0);
      chk($sformatf("bp_ready%0d", i), 32'(a_rr), 0);
      a_req = 16'(16'h0100 << i);
    end
    // Consume and accept in the same cycle: no bubble.
    a_ordy = 1'b1;
    a_req  = 16'h0040;
    #1;
    chk("bp_release_ready", 32'(a_rr), 1);
    chk("bp_release_valid", 32'(a_ov), 1);
    step();
    chk_a("bp_new", 4'd6, 1'b1, 1'b0);
    // Consume with nothing new: valid drops, fields hold.
    a_rv = 1'b0;
    step();
    chk("drain_valid", 32'(a_ov), 0);
    chk("drain_idx_hold", 32'(a_idx), 6);
    chk("drain_ready", 32'(a_rr), 1);

    // Round-robin N=16 with req=0003 held for 4 accepts.
    exp_b_idx = '{4'd0, 4'd1, 4'd0, 4'd1};
    exp_b_ptr = '{4'd1, 4'd2, 4'd1, 4'd2};
    b_rv  = 1'b1;
    b_req = 16'h0003;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr16_%0d_valid", i), 32'(b_ov), 1);
      chk($sformatf("rr16_%0d_idx", i), 32'(b_idx), 32'(exp_b_idx[i]));
      chk($sformatf("rr16_%0d_multi", i), 32'(b_multi), 1);
      chk($sformatf("rr16_%0d_ptr", i), 32'(dut_b.ptr_q), 32'(exp_b_ptr[i]));
    end
    // Empty request: no winner, pointer unchanged.
    b_req = 16'h0000;
    step();
    chk("rr16_zero_v", 32'(b_v), 0);
    chk("rr16_zero_idx", 32'(b_idx), 0);
    chk("rr16_zero_multi", 32'(b_multi), 0);
    chk("rr16_zero_ptr", 32'(dut_b.ptr_q), 2);
    // From ptr 2, bit 4 wins and ptr moves to 5.
    b_req = 16'h0010;
    step();
    chk("rr16_p5_idx", 32'(b_idx), 4);
    chk("rr16_p5_ptr", 32'(dut_b.ptr_q), 5);
    b_rv   = 1'b0;
    b_ordy = 1'b0;

    // Round-robin N=10 with req=201 for 3 accepts.
    exp_c_idx = '{4'd0, 4'd9, 4'd0};
    exp_c_ptr = '{4'd1, 4'd0, 4'd1};
    c_rv  = 1'b1;
    c_req = 10'h201;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rr10_%0d_valid", i), 32'(c_ov), 1);
      chk($sformatf("rr10_%0d_idx", i), 32'(c_idx), 32'(exp_c_idx[i]));
      chk($sformatf("rr10_%0d_ptr", i), 32'(dut_c.ptr_q), 32'(exp_c_ptr[i]));
    end
    c_rv = 1'b0;

    // Asynchronous reset between edges while B holds a result and ptr=5.
    step();
    chk("arst_pre_valid", 32'(b_ov), 1);
    chk("arst_pre_ptr", 32'(dut_b.ptr_q), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(b_ov), 0);
    chk("arst_ptr", 32'(dut_b.ptr_q), 0);
    chk("arst_idx", 32'(b_idx), 0);
    chk("arst_v", 32'(b_v), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    b_ordy = 1'b1;
    b_rv   = 1'b1;
    b_req  = 16'h0030;
    step();
    chk("arst_after_idx", 32'(b_idx), 4);
    chk("arst_after_ptr", 32'(dut_b.ptr_q), 5);
    b_rv = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
